icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 106 ++++++++++
 tb/tb_icache.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state fill FSM.
// Misses latch the request address and fetch a single word from the memory controller.
module icache #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        inv,
    output logic [15:0] hitcnt,
    output logic [15:0] misscnt
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];

    logic [TAG_W-1:0] req_tag, miss_tag;
    logic [IDX_W-1:0] req_idx, miss_idx;
    logic             hit, miss_start, fill_done;
    logic             unused_offset;

    assign req_tag       = imemaddr[31:2+IDX_W];
    assign req_idx       = imemaddr[1+IDX_W:2];
    assign unused_offset = ^imemaddr[1:0];

    assign hit        = (state == IDLE) && imemREN && !inv && valid[req_idx] && (tags[req_idx] == req_tag);
    assign miss_start = (state == IDLE) && imemREN && !inv && !hit;
    assign fill_done  = (state == FETCH) && !iwait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss_start) next_state = FETCH;
            FETCH:   if (!iwait)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iREN     = 1'b0;
        iaddr    = '0;
        ihit     = hit;
        imemload = '0;
        if (state == FETCH) begin
            iREN  = 1'b1;
            iaddr = {miss_tag, miss_idx, 2'b00};
        end
        if (hit) imemload = data[req_idx];
    end

    // A fill landing on the same edge as inv still writes tag/data, but the frame stays invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_tag <= '0;
            miss_idx <= '0;
            hitcnt   <= '0;
            misscnt  <= '0;
        end else begin
            if (miss_start) begin
                miss_tag <= req_tag;
                miss_idx <= req_idx;
                misscnt  <= misscnt + 16'd1;
            end
            if (hit) hitcnt <= hitcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: cold miss, hit stream, conflict eviction,
// mid-fill address change, invalidation and reset during a fill.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        inv;
    logic [15:0] hitcnt;
    logic [15:0] misscnt;

    int checks = 0;
    int errors = 0;

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .inv      (inv),
        .hitcnt   (hitcnt),
        .misscnt  (misscnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = '0; inv = 1'b0;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b expected 0", ihit); end
        checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h expected 0", imemload); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %b expected 0", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h expected 0", iaddr); end
        checks++; if (hitcnt !== 16'h0) begin errors++; $display("FAIL reset_hitcnt: got %h expected 0", hitcnt); end
        checks++; if (misscnt !== 16'h0) begin errors++; $display("FAIL reset_misscnt: got %h expected 0", misscnt); end
        step();
        step();
        imemREN = 1'b0;
        nRST = 1'b1;
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_miss_ihit: got %b expected 0", ihit); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL cold_idle_iREN: got %b expected 0", iREN); end
        step();
        for (int i = 0; i < 4; i++) begin
            iwait = (i < 3); iload = 32'h8C220004;
            #1;
            checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL cold_fetch_iREN[%0d]: got %b expected 1", i, iREN); end
            checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL cold_fetch_iaddr[%0d]: got %h expected 00000040", i, iaddr); end
            checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_fetch_ihit[%0d]: got %b expected 0", i, ihit); end
            step();
        end
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL cold_fill_ihit: got %b expected 1", ihit); end
        checks++; if (imemload !== 32'h8C220004) begin errors++; $display("FAIL cold_fill_data: got %h expected 8c220004", imemload); end
        checks++; if (misscnt !== 16'd1) begin errors++; $display("FAIL cold_misscnt: got %0d expected 1", misscnt); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL cold_done_iREN: got %b expected 0", iREN); end
    endtask

    task automatic test_hit_stream();
        for (int i = 0; i < 5; i++) begin
            checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL stream_ihit[%0d]: got %b expected 1", i, ihit); end
            checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL stream_iREN[%0d]: got %b expected 0", i, iREN); end
            checks++; if (imemload !== 32'h8C220004) begin errors++; $display("FAIL stream_data[%0d]: got %h expected 8c220004", i, imemload); end
            step();
            #1;
        end
        imemREN = 1'b0;
        #1;
        checks++; if (hitcnt !== 16'd5) begin errors++; $display("FAIL stream_hitcnt: got %0d expected 5", hitcnt); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL stream_noreq_ihit: got %b expected 0", ihit); end
        checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL stream_noreq_data: got %h expected 0", imemload); end
    endtask

    task automatic test_conflict();
        imemREN = 1'b1; imemaddr = 32'h80;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_80_ihit: got %b expected 0", ihit); end
        step();
        checks++; if (iaddr !== 32'h80) begin errors++; $display("FAIL conflict_80_iaddr: got %h expected 00000080", iaddr); end
        checks++; if (misscnt !== 16'd2) begin errors++; $display("FAIL conflict_misscnt2: got %0d expected 2", misscnt); end
        iwait = 1'b0; iload = 32'h11111111;
        step();
        iwait = 1'b1;
        #1;
        checks++; if (imemload !== 32'h11111111) begin errors++; $display("FAIL conflict_80_data: got %h expected 11111111", imemload); end
        imemaddr = 32'h40;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_40_evicted: got %b expected 0", ihit); end
        step();
        checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL conflict_40_iaddr: got %h expected 00000040", iaddr); end
        checks++; if (misscnt !== 16'd3) begin errors++; $display("FAIL conflict_misscnt3: got %0d expected 3", misscnt); end
        iwait = 1'b0; iload = 32'h8C220004;
        step();
        iwait = 1'b1;
        #1;
        checks++; if (imemload !== 32'h8C220004) begin errors++; $display("FAIL conflict_40_data: got %h expected 8c220004", imemload); end
        imemREN = 1'b0;
    endtask

    task automatic test_mid_fill();
        imemREN = 1'b1; imemaddr = 32'h100;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL midfill_100_ihit: got %b expected 0", ihit); end
        step();
        imemaddr = 32'h40; iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL midfill_fetch_ihit: got %b expected 0", ihit); end
        checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL midfill_iaddr_a: got %h expected 00000100", iaddr); end
        step();
        imemREN = 1'b0; imemaddr = 32'h200; iwait = 1'b0; iload = 32'h22222222;
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL midfill_iREN: got %b expected 1", iREN); end
        checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL midfill_iaddr_b: got %h expected 00000100", iaddr); end
        step();
        iwait = 1'b1; imemREN = 1'b1; imemaddr = 32'h100;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL midfill_100_hit: got %b expected 1", ihit); end
        checks++; if (imemload !== 32'h22222222) begin errors++; $display("FAIL midfill_100_data: got %h expected 22222222", imemload); end
        step();
        imemaddr = 32'h200;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL midfill_200_ihit: got %b expected 0", ihit); end
        step();
        checks++; if (iaddr !== 32'h200) begin errors++; $display("FAIL midfill_200_iaddr: got %h expected 00000200", iaddr); end
        checks++; if (misscnt !== 16'd5) begin errors++; $display("FAIL midfill_misscnt: got %0d expected 5", misscnt); end
        iwait = 1'b0; iload = 32'h33333333;
        step();
        iwait = 1'b1; imemREN = 1'b0;
        #1;
        checks++; if (hitcnt !== 16'd6) begin errors++; $display("FAIL midfill_hitcnt: got %0d expected 6", hitcnt); end
    endtask

    task automatic test_inv();
        imemREN = 1'b1; imemaddr = 32'h200;
        #1;
        checks++; if (imemload !== 32'h33333333) begin errors++; $display("FAIL inv_pre_data: got %h expected 33333333", imemload); end
        inv = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL inv_suppress_ihit: got %b expected 0", ihit); end
        step();
        inv = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL inv_no_miss_iREN: got %b expected 0", iREN); end
        checks++; if (misscnt !== 16'd5) begin errors++; $display("FAIL inv_misscnt: got %0d expected 5", misscnt); end
        checks++; if (hitcnt !== 16'd6) begin errors++; $display("FAIL inv_hitcnt: got %0d expected 6", hitcnt); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL inv_after_ihit: got %b expected 0", ihit); end
        step();
        iwait = 1'b0; iload = 32'h44444444; inv = 1'b1;
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL inv_fetch_iREN: got %b expected 1", iREN); end
        step();
        inv = 1'b0; iwait = 1'b1;
        #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL inv_fill_idle: got %b expected 0", iREN); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL inv_fill_invalid: got %b expected 0", ihit); end
        step();
        iwait = 1'b0; iload = 32'h55555555;
        #1;
        checks++; if (misscnt !== 16'd7) begin errors++; $display("FAIL inv_refetch_misscnt: got %0d expected 7", misscnt); end
        step();
        iwait = 1'b1;
        #1;
        checks++; if (imemload !== 32'h55555555) begin errors++; $display("FAIL inv_refill_data: got %h expected 55555555", imemload); end
        imemREN = 1'b0;
    endtask

    task automatic test_last_set();
        imemREN = 1'b1; imemaddr = 32'h3C;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL last_ihit: got %b expected 0", ihit); end
        step();
        checks++; if (iaddr !== 32'h3C) begin errors++; $display("FAIL last_iaddr: got %h expected 0000003c", iaddr); end
        iwait = 1'b0; iload = 32'h66666666;
        step();
        iwait = 1'b1; imemaddr = 32'h3E;
        #1;
        checks++; if (imemload !== 32'h66666666) begin errors++; $display("FAIL last_offset_data: got %h expected 66666666", imemload); end
        imemaddr = 32'h200;
        #1;
        checks++; if (imemload !== 32'h55555555) begin errors++; $display("FAIL last_set0_data: got %h expected 55555555", imemload); end
        imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        step();
        imemREN = 1'b1; imemaddr = 32'h400;
        step();
        iwait = 1'b1;
        #1;
        checks++; if (iaddr !== 32'h400) begin errors++; $display("FAIL rstfetch_iaddr: got %h expected 00000400", iaddr); end
        nRST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rstfetch_iREN: got %b expected 0", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rstfetch_iaddr0: got %h expected 0", iaddr); end
        checks++; if (hitcnt !== 16'h0) begin errors++; $display("FAIL rstfetch_hitcnt: got %0d expected 0", hitcnt); end
        checks++; if (misscnt !== 16'h0) begin errors++; $display("FAIL rstfetch_misscnt: got %0d expected 0", misscnt); end
        step();
        nRST = 1'b1; imemaddr = 32'h200;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfetch_200_cleared: got %b expected 0", ihit); end
        imemaddr = 32'h400;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfetch_400_ihit: got %b expected 0", ihit); end
        step();
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL rstfetch_refetch_iREN: got %b expected 1", iREN); end
        checks++; if (misscnt !== 16'd1) begin errors++; $display("FAIL rstfetch_refetch_misscnt: got %0d expected 1", misscnt); end
        iwait = 1'b0; iload = 32'h77777777;
        step();
        iwait = 1'b1;
        #1;
        checks++; if (imemload !== 32'h77777777) begin errors++; $display("FAIL rstfetch_refill_data: got %h expected 77777777", imemload); end
        imemREN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_conflict();
        test_mid_fill();
        test_inv();
        test_last_set();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
